// File: rtl/sparse_chunk_ring.sv
// sparse_chunk_ring: NUM_BANK-deep ring of sparse-compressed chunks.
// Optional misuse/overflow checking: define SPARSE_CHUNK_RING_OVF_CHK_EN.
module sparse_chunk_ring #(
    parameter int MEM_SIZE        = 128,
    parameter int BUS_SIZE        = 16,
    parameter int PREFIX_SUM_SIZE = 8,
    parameter int NUM_BANK        = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          wr_valid_i,
    output logic                                          wr_ready_o,
    input  logic [BUS_SIZE-1:0]                           wr_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0]                         wr_nonzero_data_i,
    output logic                                          rd_valid_o,
    input  logic [$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0]   rd_win_addr_i,
    output logic [PREFIX_SUM_SIZE-1:0]                    rd_sparsemap_o,
    input  logic [$clog2(PREFIX_SUM_SIZE)-1:0]            rd_match_i,
    output logic [7:0]                                    rd_data_o,
    input  logic                                          rd_win_end_i,
    input  logic                                          rd_chunk_end_i,
    output logic                                          full_o,
    output logic                                          empty_o,
    output logic                                          err_o
);

    localparam int BEATS = MEM_SIZE / BUS_SIZE;
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int BW    = $clog2(BEATS);
    localparam int PW    = $clog2(NUM_BANK);
    localparam int CW    = $clog2(BUS_SIZE) + 1;
    localparam int SW    = $clog2(PREFIX_SUM_SIZE) + 1;

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [AW:0]         fill_ptr_q, fill_ptr_d;
    logic [AW:0]         rd_base_q, rd_base_d;
    logic [NUM_BANK-1:0] bank_full_q, bank_full_d;

    // Chunk storage: no reset, contents only meaningful once a bank is full
    logic [MEM_SIZE-1:0] smap_q [NUM_BANK];
    logic [7:0]          data_q [NUM_BANK][MEM_SIZE];

    logic                wr_fire;
    logic                wr_last;
    logic [CW-1:0]       wr_pop;
    logic [AW:0]         wr_idx [BUS_SIZE];
    logic [BUS_SIZE-1:0] wr_en;
    logic [PREFIX_SUM_SIZE-1:0] pre_mask;
    logic [SW-1:0]       rd_pre;
    logic [SW-1:0]       win_pop;
    logic [AW+1:0]       rd_addr;

    assign wr_ready_o = !bank_full_q[wr_ptr_q];
    assign rd_valid_o = bank_full_q[rd_ptr_q];
    assign full_o     = &bank_full_q;
    assign empty_o    = ~|bank_full_q;
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign wr_last    = wr_fire && (beat_cnt_q == BW'(BEATS - 1));

    // Per-byte compaction targets for the incoming beat
    always_comb begin
        wr_pop = CW'($countones(wr_sparsemap_i));
        for (int j = 0; j < BUS_SIZE; j++) begin
            wr_idx[j] = fill_ptr_q + (AW+1)'(j);
            wr_en[j]  = wr_fire && (CW'(j) < wr_pop);
`ifdef SPARSE_CHUNK_RING_OVF_CHK_EN
            if (wr_idx[j] >= (AW+1)'(MEM_SIZE)) wr_en[j] = 1'b0;
`endif
        end
    end

    // Window select and exclusive prefix-sum addressing into the read bank
    always_comb begin
        rd_sparsemap_o = smap_q[rd_ptr_q][rd_win_addr_i*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE];
        pre_mask  = (PREFIX_SUM_SIZE'(1) << rd_match_i) - PREFIX_SUM_SIZE'(1);
        rd_pre    = SW'($countones(rd_sparsemap_o & pre_mask));
        win_pop   = SW'($countones(rd_sparsemap_o));
        rd_addr   = (AW+2)'(rd_base_q) + (AW+2)'(rd_pre);
        rd_data_o = data_q[rd_ptr_q][rd_addr[AW-1:0]];
    end

    // Next-state for pointers, fill level, read base and bank occupancy
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        fill_ptr_d  = fill_ptr_q;
        rd_base_d   = rd_base_q;
        bank_full_d = bank_full_q;
        if (wr_fire) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
            fill_ptr_d = fill_ptr_q + (AW+1)'(wr_pop);
        end
        if (rd_valid_o && rd_chunk_end_i) begin
            bank_full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d  = rd_ptr_q + PW'(1);
            rd_base_d = '0;
        end else if (rd_valid_o && rd_win_end_i) begin
            rd_base_d = rd_base_q + (AW+1)'(win_pop);
        end
        if (wr_last) begin
            bank_full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            beat_cnt_d = '0;
            fill_ptr_d = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            fill_ptr_q  <= '0;
            rd_base_q   <= '0;
            bank_full_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_base_q   <= rd_base_d;
            bank_full_q <= bank_full_d;
        end
    end

    // Chunk storage writes: sparsemap slice plus compacted non-zero bytes
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            smap_q[wr_ptr_q][beat_cnt_q*BUS_SIZE +: BUS_SIZE] <= wr_sparsemap_i;
        end
        for (int j = 0; j < BUS_SIZE; j++) begin
            if (wr_en[j]) begin
                data_q[wr_ptr_q][wr_idx[j][AW-1:0]] <= wr_nonzero_data_i[j*8 +: 8];
            end
        end
    end

`ifdef SPARSE_CHUNK_RING_OVF_CHK_EN
    logic          err_q, err_d;
    logic [AW+1:0] fill_sum;

    // Sticky error: fill overflow, strobes on an empty read bank, bad address
    always_comb begin
        fill_sum = (AW+2)'(fill_ptr_q) + (AW+2)'(wr_pop);
        err_d    = err_q;
        if (wr_fire && (fill_sum > (AW+2)'(MEM_SIZE))) err_d = 1'b1;
        if (!rd_valid_o && (rd_win_end_i || rd_chunk_end_i)) err_d = 1'b1;
        if (rd_valid_o && rd_sparsemap_o[rd_match_i] &&
            (rd_addr >= (AW+2)'(MEM_SIZE))) err_d = 1'b1;
    end

    // Error flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_chunk_ring.sv
// tb_sparse_chunk_ring: scoreboard bench with a chunk-queue reference model.
// Honours SPARSE_CHUNK_RING_OVF_CHK_EN when the design is built with it.
module tb_sparse_chunk_ring;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         wr_valid_i;
    logic         wr_ready_o;
    logic [15:0]  wr_sparsemap_i;
    logic [127:0] wr_nonzero_data_i;
    logic         rd_valid_o;
    logic [3:0]   rd_win_addr_i;
    logic [7:0]   rd_sparsemap_o;
    logic [2:0]   rd_match_i;
    logic [7:0]   rd_data_o;
    logic         rd_win_end_i;
    logic         rd_chunk_end_i;
    logic         full_o;
    logic         empty_o;
    logic         err_o;

    sparse_chunk_ring dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_sparsemap_i(wr_sparsemap_i), .wr_nonzero_data_i(wr_nonzero_data_i),
        .rd_valid_o(rd_valid_o), .rd_win_addr_i(rd_win_addr_i),
        .rd_sparsemap_o(rd_sparsemap_o), .rd_match_i(rd_match_i),
        .rd_data_o(rd_data_o), .rd_win_end_i(rd_win_end_i),
        .rd_chunk_end_i(rd_chunk_end_i), .full_o(full_o),
        .empty_o(empty_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       valid, full, empty, ready, err;
        bit         chk_map, chk_data;
        logic [7:0] smap, data;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a queue of complete chunks plus the chunk being built
    logic [127:0]  m_map[$];
    logic [1023:0] m_dat[$];
    int            m_cnt[$];
    logic [127:0]  cur_map;
    logic [1023:0] cur_dat;
    int            cur_fill, cur_beat, m_base;
    bit            m_err;

    task automatic model_reset();
        m_map.delete(); m_dat.delete(); m_cnt.delete();
        cur_map = '0; cur_dat = '0; cur_fill = 0; cur_beat = 0;
        m_base = 0; m_err = 0;
    endtask

    task automatic cmp(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: pops and checks expectations at every falling edge
    initial begin
        forever begin
            @(negedge clk_i);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                cmp({e.tag, ".rd_valid"}, int'(rd_valid_o), int'(e.valid));
                cmp({e.tag, ".wr_ready"}, int'(wr_ready_o), int'(e.ready));
                cmp({e.tag, ".full"},     int'(full_o),     int'(e.full));
                cmp({e.tag, ".empty"},    int'(empty_o),    int'(e.empty));
                cmp({e.tag, ".err"},      int'(err_o),      int'(e.err));
                if (e.chk_map)  cmp({e.tag, ".smap"}, int'(rd_sparsemap_o), int'(e.smap));
                if (e.chk_data) cmp({e.tag, ".data"}, int'(rd_data_o),      int'(e.data));
            end
        end
    end

    // Drive a window probe and queue what the outputs must show
    task automatic probe(string tag, input logic [3:0] w, input logic [2:0] m);
        exp_t       e;
        logic [7:0] mask;
        int         idx;
        rd_win_addr_i = w;
        rd_match_i    = m;
        e.tag   = tag;
        e.valid = m_map.size() > 0;
        e.full  = m_map.size() == 4;
        e.empty = m_map.size() == 0;
        e.ready = m_map.size() < 4;
        e.err   = m_err;
        e.chk_map = 0; e.chk_data = 0; e.smap = '0; e.data = '0;
        if (e.valid) begin
            e.chk_map = 1;
            e.smap    = m_map[0][w*8 +: 8];
            mask      = 8'((1 << m) - 1);
            idx       = m_base + $countones(e.smap & mask);
            if (e.smap[m] && idx < m_cnt[0]) begin
                e.chk_data = 1;
                e.data     = m_dat[0][idx*8 +: 8];
            end
        end
        exp_q.push_back(e);
        @(negedge clk_i);
        #1;
    endtask

    // Offer one write beat, waiting a bounded time for acceptance
    task automatic wr_beat(input logic [15:0] map, input logic [127:0] dat);
        bit ok = 0;
        int pop;
        wr_valid_i = 1'b1;
        wr_sparsemap_i = map;
        wr_nonzero_data_i = dat;
        for (int t = 0; t < 50; t++) begin
            if (wr_ready_o) begin ok = 1; break; end
            @(posedge clk_i); #1;
        end
        if (ok) begin
            @(posedge clk_i); #1;
            pop = $countones(map);
            cur_map[cur_beat*16 +: 16] = map;
            for (int k = 0; k < pop; k++)
                cur_dat[(cur_fill+k)*8 +: 8] = dat[k*8 +: 8];
            cur_fill += pop;
            cur_beat++;
            if (cur_beat == 8) begin
                m_map.push_back(cur_map);
                m_dat.push_back(cur_dat);
                m_cnt.push_back(cur_fill);
                cur_map = '0; cur_dat = '0; cur_fill = 0; cur_beat = 0;
            end
        end else begin
            checks++; errors++;
            $display("FAIL wr_accept_timeout: got ready=0 expected ready=1");
        end
        wr_valid_i = 1'b0;
    endtask

    task automatic strobe(input logic we, input logic ce, input logic [3:0] w);
        rd_win_addr_i  = w;
        rd_win_end_i   = we;
        rd_chunk_end_i = ce;
        @(posedge clk_i); #1;
        rd_win_end_i = 0; rd_chunk_end_i = 0; rd_match_i = 0;
        if (m_map.size() > 0) begin
            if (ce) begin
                void'(m_map.pop_front()); void'(m_dat.pop_front());
                void'(m_cnt.pop_front());
                m_base = 0;
            end else if (we) begin
                m_base += $countones(m_map[0][w*8 +: 8]);
            end
        end else if (we || ce) begin
`ifdef SPARSE_CHUNK_RING_OVF_CHK_EN
            m_err = 1;
`endif
        end
    endtask

    function automatic logic [127:0] seq_data();
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(k + 1);
        return d;
    endfunction

    function automatic logic [127:0] rnd_data();
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        int rw;
        logic [127:0] hold_d;
        logic [15:0]  hold_m;
        rst_ni = 0; wr_valid_i = 0; wr_sparsemap_i = 0; wr_nonzero_data_i = 0;
        rd_win_addr_i = 0; rd_match_i = 0; rd_win_end_i = 0; rd_chunk_end_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        probe("reset", 4'd0, 3'd0);
        rst_ni = 1;
        @(posedge clk_i); #1;

        // Strobe on an empty ring
        strobe(1'b1, 1'b0, 4'd0);
        probe("empty_strobe", 4'd0, 3'd0);
        probe("empty_strobe_held", 4'd0, 3'd0);

        // One chunk of 00FF beats with bytes 1..8
        for (int b = 0; b < 8; b++) wr_beat(16'h00FF, seq_data());
        probe("bank0_w0m3", 4'd0, 3'd3);
        probe("bank0_w1m0", 4'd1, 3'd0);
        strobe(1'b1, 1'b0, 4'd0);
        probe("bank0_w2m0", 4'd2, 3'd0);
        probe("bank0_w2m5", 4'd2, 3'd5);
        strobe(1'b0, 1'b1, 4'd0);
        probe("released", 4'd0, 3'd0);

        // Fill all four banks, then hold a fifth beat
        for (int c = 0; c < 32; c++) wr_beat(16'($urandom), rnd_data());
        probe("full", 4'd0, 3'd2);
        hold_m = 16'hA5C3; hold_d = rnd_data();
        wr_valid_i = 1; wr_sparsemap_i = hold_m; wr_nonzero_data_i = hold_d;
        repeat (3) begin @(posedge clk_i); #1; end
        probe("held", 4'd3, 3'd1);
        strobe(1'b0, 1'b1, 4'd0);
        probe("after_release", 4'd0, 3'd4);
        wr_beat(hold_m, hold_d);

        // Window end and chunk end together: chunk end wins
        strobe(1'b1, 1'b0, 4'd0);
        strobe(1'b1, 1'b1, 4'd1);
        probe("both_strobes", 4'd0, 3'd0);
        probe("both_strobes_m7", 4'd0, 3'd7);

        // Asynchronous reset in the middle of a chunk
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 4'd0);
        for (int b = 0; b < 3; b++) wr_beat(16'hFFFF, rnd_data());
        #2;
        rst_ni = 0;
        #1;
        model_reset();
        probe("mid_reset", 4'd0, 3'd0);
        rst_ni = 1;
        for (int b = 0; b < 8; b++) wr_beat(16'h0F0F, rnd_data());
        probe("post_reset_w0m0", 4'd0, 3'd0);
        probe("post_reset_w2m3", 4'd2, 3'd3);

        // Randomised producer / in-order consumer traffic
        rw = 0;
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                if (m_map.size() < 4) wr_beat(16'($urandom), rnd_data());
            end else if (r <= 6) begin
                probe("rand", 4'(rw), 3'($urandom_range(0, 7)));
            end else if (r <= 8) begin
                if (m_map.size() > 0) begin
                    if (rw == 15) begin
                        strobe(1'b1, 1'b1, 4'(rw));
                        rw = 0;
                    end else begin
                        strobe(1'b1, 1'b0, 4'(rw));
                        rw++;
                    end
                end
            end else begin
                if (m_map.size() > 0) begin
                    strobe(1'b0, 1'b1, 4'(rw));
                    rw = 0;
                end
            end
        end
        probe("final", 4'(rw), 3'd0);

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk_i);
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
